// File: rtl/ss_pkg.sv
// Shared types and sizing helpers for the ss read-data stage and its neighbours.
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ss_rd_state_e;

    // Two spare slots beyond the read latency keep issue running while the head waits for ready.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/ss_sync_fifo.sv
// Small show-ahead synchronous FIFO with occupancy count; reusable by other pipeline stages.
module ss_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign o_full    = (count_r == CNT_W'(DEPTH));
    assign o_empty   = (count_r == {CNT_W{1'b0}});
    assign o_count   = count_r;
    assign push_ok_s = i_push & ~o_full;
    assign pop_ok_s  = i_pop & ~o_empty;

    // Head is forced to zero when empty so no stale word is ever presented.
    always_comb begin
        if (o_empty) begin
            o_rdata = {WIDTH{1'b0}};
        end else begin
            o_rdata = mem_r[rd_ptr_r];
        end
    end

    // Storage array; flushed on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= i_wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (pop_ok_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    ss_sync_fifo_chk u_chk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (i_push),
        .i_full (o_full)
    );

endmodule

// File: rtl/ss_sync_fifo_chk.sv
// Property checker for ss_sync_fifo: a push must never land on a full FIFO.
module ss_sync_fifo_chk (
    input logic i_clk,
    input logic i_rst,
    input logic i_push,
    input logic i_full
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && i_full));

endmodule

// File: rtl/ss_read_data.sv
// Reads RAM range [si..ei] after a start edge and streams it out on valid/ready,
// using credits so the output FIFO can absorb both read latency and backpressure.
module ss_read_data
    import ss_pkg::*;
#(
    parameter int SIZE_ADDR = 6,
    parameter int SIZE_DATA = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start_read_data,
    input  logic [SIZE_ADDR-1:0] i_si_ram,
    input  logic [SIZE_ADDR-1:0] i_ei_ram,
    output logic                 o_re_ram,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    input  logic [SIZE_DATA-1:0] i_data_ram,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_busy,
    output logic                 o_done_read_data
);

    localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int LEN_W      = SIZE_ADDR + 1;

    ss_rd_state_e         state_r;
    ss_rd_state_e         state_nxt_s;
    logic                 start_q_r;
    logic                 start_edge_s;
    logic [SIZE_ADDR-1:0] addr_r;
    logic [LEN_W-1:0]     issue_cnt_r;
    logic [LEN_W-1:0]     len_s;
    logic [RD_LAT-1:0]    vld_sr_r;
    logic [CNT_W-1:0]     inflight_s;
    logic [CNT_W-1:0]     fifo_count_s;
    logic                 credit_ok_s;
    logic                 re_s;
    logic                 pop_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;

    assign start_edge_s = i_start_read_data & ~start_q_r;
    // Subtraction is self-determined at address width, giving the wrap-around length.
    assign len_s        = {1'b0, (i_ei_ram - i_si_ram)} + LEN_W'(1);
    assign pop_s        = ~fifo_empty_s & i_data_ready;

    // Words in flight and buffered together must fit the FIFO; a same-cycle pop is not credited.
    always_comb begin
        inflight_s = {CNT_W{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + CNT_W'(vld_sr_r[i]);
        end
        credit_ok_s = (({1'b0, inflight_s} + {1'b0, fifo_count_s}) < (CNT_W + 1)'(FIFO_DEPTH));
        if (state_r == READ) begin
            re_s = credit_ok_s;
        end else begin
            re_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_edge_s) state_nxt_s = READ;
                else              state_nxt_s = IDLE;
            end
            READ: begin
                if (re_s && (issue_cnt_r == LEN_W'(1))) state_nxt_s = DRAIN;
                else                                    state_nxt_s = READ;
            end
            DRAIN: begin
                if ((inflight_s == {CNT_W{1'b0}}) &&
                    ((fifo_count_s == {CNT_W{1'b0}}) || ((fifo_count_s == CNT_W'(1)) && pop_s)))
                    state_nxt_s = DONE;
                else
                    state_nxt_s = DRAIN;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, start-edge flop, address/issue counters and read-latency tracker.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            start_q_r   <= 1'b0;
            addr_r      <= {SIZE_ADDR{1'b0}};
            issue_cnt_r <= {LEN_W{1'b0}};
            vld_sr_r    <= {RD_LAT{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            start_q_r   <= i_start_read_data;
            vld_sr_r[0] <= re_s;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
            end
            if ((state_r == IDLE) && start_edge_s) begin
                addr_r      <= i_si_ram;
                issue_cnt_r <= len_s;
            end else if (re_s) begin
                addr_r      <= addr_r + SIZE_ADDR'(1);
                issue_cnt_r <= issue_cnt_r - LEN_W'(1);
            end
        end
    end

    ss_sync_fifo #(
        .WIDTH (SIZE_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (vld_sr_r[RD_LAT-1]),
        .i_wdata (i_data_ram),
        .i_pop   (pop_s),
        .o_rdata (o_data),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s),
        .o_count (fifo_count_s)
    );

    assign o_re_ram         = re_s;
    assign o_addr_ram       = addr_r;
    assign o_data_valid     = ~fifo_empty_s;
    assign o_busy           = (state_r != IDLE);
    assign o_done_read_data = (state_r == DONE);

endmodule
